// File: rtl/alu_result_serializer_pkg.sv
// Shared types and sizing helpers for the ALU result serializer.
package alu_result_serializer_pkg;

    localparam int unsigned DEF_WIDTH  = 16;
    localparam int unsigned DEF_BYTE_W = 8;

    // Bytes per result word and the width of the byte counter that walks them.
    function automatic int unsigned nbytes_f(input int unsigned width, input int unsigned byte_w);
        return (2 * width) / byte_w;
    endfunction

    function automatic int unsigned cnt_w_f(input int unsigned nbytes);
        return (nbytes > 1) ? $clog2(nbytes) : 1;
    endfunction

    localparam int unsigned NBYTES = nbytes_f(DEF_WIDTH, DEF_BYTE_W);
    localparam int unsigned CNT_W  = cnt_w_f(NBYTES);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/alu_result_serializer_if.sv
// Result capture and byte-stream handshake bundle between ALU, serializer and TX path.
interface alu_result_serializer_if
    import alu_result_serializer_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned BYTE_W = DEF_BYTE_W
);

    logic [2*WIDTH-1:0] res_in;
    logic               res_valid;
    logic [BYTE_W-1:0]  byte_out;
    logic               byte_valid;
    logic               byte_ready;
    logic               frame_done;
    logic               busy;
    logic               overflow;

    // Environment side: supplies results and the downstream ready.
    modport master (
        output res_in, res_valid, byte_ready,
        input  byte_out, byte_valid, frame_done, busy, overflow
    );

    // Serializer side.
    modport slave (
        input  res_in, res_valid, byte_ready,
        output byte_out, byte_valid, frame_done, busy, overflow
    );

endinterface

// File: rtl/alu_result_serializer_result_fifo.sv
// Small synchronous FIFO holding pending result words; never drops data itself.
module result_fifo #(
    parameter int unsigned DW       = 32,
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned CNT_BITS = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [DW-1:0]       wr_data,
    input  logic                rd_en,
    output logic [DW-1:0]       rd_data,
    output logic [CNT_BITS-1:0] count,
    output logic                full,
    output logic                empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [DW-1:0]       mem_q [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_BITS-1:0] count_q, count_d;

    // Pointer advance and occupancy update; simultaneous push/pop keeps count.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
        end
        if (rd_en) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
        end
        if (wr_en && !rd_en) begin
            count_d = count_q + 1'b1;
        end else if (!wr_en && rd_en) begin
            count_d = count_q - 1'b1;
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage; when full, a write with a pop lands in the slot being read out this edge.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;
    assign full    = (count_q == CNT_BITS'(DEPTH));
    assign empty   = (count_q == '0);

endmodule

// File: rtl/alu_result_serializer.sv
// Captures registered ALU results into a 2-deep buffer and streams them out LSB byte first.
module alu_result_serializer
    import alu_result_serializer_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned BYTE_W = DEF_BYTE_W,
    parameter int unsigned DEPTH  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    alu_result_serializer_if.slave ser
);

    localparam int unsigned DW       = 2 * WIDTH;
    localparam int unsigned NB       = nbytes_f(WIDTH, BYTE_W);
    localparam int unsigned CW       = cnt_w_f(NB);
    localparam int unsigned CNT_BITS = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(NB - 1);

    state_t               state_q, state_d;
    logic [DW-1:0]        sh_q, sh_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 frame_done_q, frame_done_d;
    logic                 overflow_q, overflow_d;
    logic                 cap_q;

    logic                 fifo_wr_en;
    logic                 fifo_rd_en;
    logic [DW-1:0]        fifo_rd_data;
    logic [CNT_BITS-1:0]  fifo_count;
    logic                 fifo_full;
    logic                 fifo_empty;

    result_fifo #(
        .DW       (DW),
        .DEPTH    (DEPTH),
        .CNT_BITS (CNT_BITS)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (fifo_wr_en),
        .wr_data (ser.res_in),
        .rd_en   (fifo_rd_en),
        .rd_data (fifo_rd_data),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Delay the ALU flag by one cycle so res_in has settled when it is written.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap_q <= 1'b0;
        end else begin
            cap_q <= ser.res_valid;
        end
    end

    // A capture into a full buffer survives only if the head is popped on the same edge.
    always_comb begin
        fifo_wr_en = cap_q && (!fifo_full || fifo_rd_en);
        overflow_d = overflow_q || (cap_q && fifo_full && !fifo_rd_en);
    end

    // Sender next-state: load head word, shift per accepted byte, chain frames without a gap.
    always_comb begin
        state_d      = state_q;
        sh_d         = sh_q;
        cnt_d        = cnt_q;
        frame_done_d = 1'b0;
        fifo_rd_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_rd_en = 1'b1;
                    sh_d       = fifo_rd_data;
                    cnt_d      = '0;
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (ser.byte_ready) begin
                    if (cnt_q == LAST_CNT) begin
                        frame_done_d = 1'b1;
                        cnt_d        = '0;
                        if (!fifo_empty) begin
                            fifo_rd_en = 1'b1;
                            sh_d       = fifo_rd_data;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        sh_d  = sh_q >> BYTE_W;
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Sender state, shift register, byte counter and status flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            sh_q         <= '0;
            cnt_q        <= '0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            sh_q         <= sh_d;
            cnt_q        <= cnt_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
        end
    end

    assign ser.byte_out   = sh_q[BYTE_W-1:0];
    assign ser.byte_valid = (state_q == SEND);
    assign ser.frame_done = frame_done_q;
    assign ser.overflow   = overflow_q;
    assign ser.busy       = (fifo_count != '0) || (state_q == SEND);

endmodule

// File: tb/tb_alu_result_serializer.sv
// Randomized and directed bench for the ALU result serializer against a byte-stream model.
module tb_alu_result_serializer;
    import alu_result_serializer_pkg::*;

    logic clk;
    logic rst;

    alu_result_serializer_if #(.WIDTH(16), .BYTE_W(8)) bus ();

    alu_result_serializer #(
        .WIDTH  (16),
        .BYTE_W (8),
        .DEPTH  (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .ser (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]  got[$];
    logic [7:0]  exp[$];
    int          frames;
    bit          pend_v;
    logic [31:0] pend_w;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Expected stream: each accepted word contributes its bytes least-significant first.
    function automatic void push_word(input logic [31:0] w);
        for (int i = 0; i < NBYTES; i++) begin
            exp.push_back(8'(w >> (8 * i)));
        end
    endfunction

    // One clock of stimulus. res_valid is the ALU flag for this cycle; the
    // matching result appears on res_in one cycle later, as from a registered ALU.
    task automatic cycle(input bit v, input logic [31:0] w, input bit rdy);
        @(negedge clk);
        if (pend_v) bus.res_in = pend_w;
        bus.res_valid  = v;
        bus.byte_ready = rdy;
        pend_v = v;
        pend_w = w;
        #1;
        if (rst && bus.byte_valid && bus.byte_ready) got.push_back(bus.byte_out);
        if (bus.frame_done) frames++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        bus.res_valid  = 1'b0;
        bus.byte_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        got.delete();
        exp.delete();
        frames = 0;
        pend_v = 1'b0;
    endtask

    task automatic test_reset();
        logic [11:0] obs;
        #1;
        obs = {bus.byte_out, bus.byte_valid, bus.frame_done, bus.busy, bus.overflow};
        checks++;
        if (obs !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 000", obs);
        end
        do_reset();
    endtask

    task automatic test_basic();
        do_reset();
        push_word(32'h1234ABCD);
        cycle(1'b1, 32'h1234ABCD, 1'b1);
        cycle(1'b0, '0, 1'b1);
        checks++;
        if (bus.byte_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_latency_e1: byte_valid %b expected 0", bus.byte_valid);
        end
        cycle(1'b0, '0, 1'b1);
        checks++;
        if ({bus.byte_valid, bus.busy} !== 2'b01) begin
            errors++;
            $display("FAIL basic_latency_e2: valid,busy %b expected 01", {bus.byte_valid, bus.busy});
        end
        cycle(1'b0, '0, 1'b1);
        checks++;
        if ({bus.byte_valid, bus.byte_out} !== 9'h1CD) begin
            errors++;
            $display("FAIL basic_first_byte: valid,byte %h expected 1cd", {bus.byte_valid, bus.byte_out});
        end
        for (int k = 0; k < 3; k++) cycle(1'b0, '0, 1'b1);
        checks++;
        if (frames !== 0) begin
            errors++;
            $display("FAIL basic_early_done: frames %0d expected 0", frames);
        end
        cycle(1'b0, '0, 1'b1);
        checks++;
        if ({bus.frame_done, bus.busy, bus.byte_valid} !== 3'b100) begin
            errors++;
            $display("FAIL basic_done: done,busy,valid %b expected 100", {bus.frame_done, bus.busy, bus.byte_valid});
        end
        cycle(1'b0, '0, 1'b1);
        checks++;
        if (bus.frame_done !== 1'b0 || frames !== 1) begin
            errors++;
            $display("FAIL basic_pulse: done %b frames %0d expected 0 and 1", bus.frame_done, frames);
        end
        checks++;
        if (got.size() != exp.size()) begin
            errors++;
            $display("FAIL basic_count: got %0d bytes expected %0d", got.size(), exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                checks++;
                if (got[i] !== exp[i]) begin
                    errors++;
                    $display("FAIL basic_byte%0d: got %h expected %h", i, got[i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int n;
        do_reset();
        push_word(32'h1234ABCD);
        cycle(1'b1, 32'h1234ABCD, 1'b1);
        n = 0;
        while (got.size() < 1 && n < 20) begin
            cycle(1'b0, '0, 1'b1);
            n++;
        end
        for (int k = 0; k < 5; k++) begin
            cycle(1'b0, '0, 1'b0);
            checks++;
            if ({bus.byte_valid, bus.byte_out} !== 9'h1AB) begin
                errors++;
                $display("FAIL bp_hold%0d: valid,byte %h expected 1ab", k, {bus.byte_valid, bus.byte_out});
            end
        end
        n = 0;
        while (frames < 1 && n < 20) begin
            cycle(1'b0, '0, 1'b1);
            n++;
        end
        checks++;
        if (got.size() != exp.size()) begin
            errors++;
            $display("FAIL bp_count: got %0d bytes expected %0d", got.size(), exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                checks++;
                if (got[i] !== exp[i]) begin
                    errors++;
                    $display("FAIL bp_byte%0d: got %h expected %h", i, got[i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int  n;
        int  gaps;
        bit  started;
        logic [31:0] words [3];
        words[0] = 32'h11111111;
        words[1] = 32'h22222222;
        words[2] = 32'h33333333;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            push_word(words[k]);
            cycle(1'b1, words[k], 1'b1);
        end
        n = 0;
        gaps = 0;
        started = 1'b0;
        while (got.size() < 12 && n < 40) begin
            cycle(1'b0, '0, 1'b1);
            if (bus.byte_valid) started = 1'b1;
            else if (started) gaps++;
            n++;
        end
        repeat (2) cycle(1'b0, '0, 1'b1);
        checks++;
        if (gaps != 0 || bus.overflow !== 1'b0 || frames != 3) begin
            errors++;
            $display("FAIL b2b_flow: gaps %0d overflow %b frames %0d expected 0 0 3", gaps, bus.overflow, frames);
        end
        checks++;
        if (got.size() != exp.size()) begin
            errors++;
            $display("FAIL b2b_count: got %0d bytes expected %0d", got.size(), exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                checks++;
                if (got[i] !== exp[i]) begin
                    errors++;
                    $display("FAIL b2b_byte%0d: got %h expected %h", i, got[i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_overflow();
        int n;
        do_reset();
        // One word parked in the sender, two buffered, the next one has nowhere to go.
        push_word(32'h5A5A5A5A);
        cycle(1'b1, 32'h5A5A5A5A, 1'b0);
        repeat (4) cycle(1'b0, '0, 1'b0);
        checks++;
        if (bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_early: overflow %b expected 0", bus.overflow);
        end
        push_word(32'hAAAA0001);
        cycle(1'b1, 32'hAAAA0001, 1'b0);
        push_word(32'hBBBB0002);
        cycle(1'b1, 32'hBBBB0002, 1'b0);
        cycle(1'b1, 32'hCCCC0003, 1'b0);
        repeat (4) cycle(1'b0, '0, 1'b0);
        checks++;
        if (bus.overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set: overflow %b expected 1", bus.overflow);
        end
        n = 0;
        while (got.size() < 12 && n < 40) begin
            cycle(1'b0, '0, 1'b1);
            n++;
        end
        repeat (8) cycle(1'b0, '0, 1'b1);
        checks++;
        if (bus.overflow !== 1'b1 || frames != 3 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL ovf_after: overflow %b frames %0d busy %b expected 1 3 0", bus.overflow, frames, bus.busy);
        end
        checks++;
        if (got.size() != exp.size()) begin
            errors++;
            $display("FAIL ovf_count: got %0d bytes expected %0d", got.size(), exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                checks++;
                if (got[i] !== exp[i]) begin
                    errors++;
                    $display("FAIL ovf_byte%0d: got %h expected %h", i, got[i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_reset_midframe();
        int n;
        logic [11:0] obs;
        do_reset();
        cycle(1'b1, 32'hDEADBEEF, 1'b1);
        n = 0;
        while (got.size() < 2 && n < 20) begin
            cycle(1'b0, '0, 1'b1);
            n++;
        end
        checks++;
        if (got.size() != 2 || got[0] !== 8'hEF || got[1] !== 8'hBE) begin
            errors++;
            $display("FAIL rstmid_prefix: got %0d bytes expected EF BE", got.size());
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        obs = {bus.byte_out, bus.byte_valid, bus.frame_done, bus.busy, bus.overflow};
        checks++;
        if (obs !== 12'h000) begin
            errors++;
            $display("FAIL rstmid_outputs: got %h expected 000", obs);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        got.delete();
        exp.delete();
        frames = 0;
        pend_v = 1'b0;
        push_word(32'h00000001);
        cycle(1'b1, 32'h00000001, 1'b1);
        n = 0;
        while (frames < 1 && n < 20) begin
            cycle(1'b0, '0, 1'b1);
            n++;
        end
        checks++;
        if (got.size() != exp.size()) begin
            errors++;
            $display("FAIL rstmid_count: got %0d bytes expected %0d", got.size(), exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                checks++;
                if (got[i] !== exp[i]) begin
                    errors++;
                    $display("FAIL rstmid_byte%0d: got %h expected %h", i, got[i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_full_pop();
        int n;
        do_reset();
        push_word(32'h01020304);
        cycle(1'b1, 32'h01020304, 1'b0);
        repeat (3) cycle(1'b0, '0, 1'b0);
        push_word(32'h05060708);
        cycle(1'b1, 32'h05060708, 1'b0);
        push_word(32'h090A0B0C);
        cycle(1'b1, 32'h090A0B0C, 1'b0);
        repeat (3) cycle(1'b0, '0, 1'b0);
        // Three bytes of the first frame, then the last byte leaves on the capture edge.
        repeat (3) cycle(1'b0, '0, 1'b1);
        push_word(32'h0D0E0F10);
        cycle(1'b1, 32'h0D0E0F10, 1'b0);
        cycle(1'b0, '0, 1'b1);
        n = 0;
        while (got.size() < 16 && n < 40) begin
            cycle(1'b0, '0, 1'b1);
            n++;
        end
        repeat (4) cycle(1'b0, '0, 1'b1);
        checks++;
        if (bus.overflow !== 1'b0 || frames != 4) begin
            errors++;
            $display("FAIL fullpop_flags: overflow %b frames %0d expected 0 4", bus.overflow, frames);
        end
        checks++;
        if (got.size() != exp.size()) begin
            errors++;
            $display("FAIL fullpop_count: got %0d bytes expected %0d", got.size(), exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                checks++;
                if (got[i] !== exp[i]) begin
                    errors++;
                    $display("FAIL fullpop_byte%0d: got %h expected %h", i, got[i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        int  issued;
        int  n;
        bit  v;
        bit  rdy;
        logic [31:0] w;
        do_reset();
        issued = 0;
        n = 0;
        // Never more than three results in flight, which the block can always hold.
        while ((issued < 40 || frames < 40) && n < 4000) begin
            rdy = ($urandom_range(0, 9) < 7);
            w   = $urandom;
            v   = (issued < 40) && ((issued - frames) < 3) && ($urandom_range(0, 1) == 1);
            if (v) begin
                push_word(w);
                issued++;
            end
            cycle(v, w, rdy);
            n++;
        end
        checks++;
        if (n >= 4000 || bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL rand_progress: cycles %0d frames %0d overflow %b expected <4000 40 0", n, frames, bus.overflow);
        end
        checks++;
        if (got.size() != exp.size()) begin
            errors++;
            $display("FAIL rand_count: got %0d bytes expected %0d", got.size(), exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                checks++;
                if (got[i] !== exp[i]) begin
                    errors++;
                    $display("FAIL rand_byte%0d: got %h expected %h", i, got[i], exp[i]);
                end
            end
        end
    endtask

    initial begin
        rst            = 1'b0;
        bus.res_in     = '0;
        bus.res_valid  = 1'b0;
        bus.byte_ready = 1'b0;
        frames         = 0;
        pend_v         = 1'b0;
        pend_w         = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_overflow();
        test_reset_midframe();
        test_full_pop();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
